// File: rtl/clock_divider.sv
`default_nettype none
// ============================================================================
// clock_divider : 50%-duty integer clock divider with optional rising strobe
// Optional feature macro: CLOCK_DIVIDER_TICK_EN.
// Revision 1.0 : initial release
// ============================================================================
module clock_divider #(
    parameter int IN_HZ  = 50_000_000,
    parameter int OUT_HZ = 20
) (
    input  logic clk50,
    input  logic rst_n,
    output logic clk_div,
    output logic tick
);

    localparam int HALF = (OUT_HZ > 0) ? IN_HZ / (2 * OUT_HZ) : 0;
    localparam int CW   = ($clog2(HALF) > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    generate
        if (OUT_HZ <= 0 || IN_HZ < 2 * OUT_HZ) begin : g_bad_ratio
            $error("clock_divider: need OUT_HZ > 0 and IN_HZ >= 2*OUT_HZ");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_div <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            clk_div <= ~clk_div;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

`ifdef CLOCK_DIVIDER_TICK_EN
    // A wrap while clk_div is low is exactly the edge on which it rises.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap & ~clk_div;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// tb_clock_divider : directed vectors for HALF=5 and HALF=1 instances,
// plus continued-period and asynchronous mid-period reset sequences.
module tb_clock_divider;

`ifdef CLOCK_DIVIDER_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;
    logic div5, tick5, div1, tick1;

    always #5 clk50 = ~clk50;

    clock_divider #(.IN_HZ(100), .OUT_HZ(10)) u_div5 (
        .clk50(clk50), .rst_n(rst_n), .clk_div(div5), .tick(tick5)
    );

    clock_divider #(.IN_HZ(50), .OUT_HZ(25)) u_div1 (
        .clk50(clk50), .rst_n(rst_n), .clk_div(div1), .tick(tick1)
    );

    typedef struct {
        int   edge_n;
        logic d5;
        logic t5;
        logic d1;
        logic t1;
    } vec_t;

    vec_t vecs[14];
    int   total = 0;
    int   bad   = 0;
    int   n     = 0;

    task automatic check(input string name, input int at, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, at, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        #1;
        n++;
    endtask

    initial begin
        // edge_n counts rising clk50 edges since reset release.
        vecs[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{5,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{9,  1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{11, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{14, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{15, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{16, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{20, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{25, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk50);
        #1;
        rst_n = 1'b1;
        n = 0;

        for (int i = 0; i < 14; i++) begin
            while (n < vecs[i].edge_n) step();
            check("div5",  n, div5,  vecs[i].d5);
            check("tick5", n, tick5, vecs[i].t5 & TICK_ON);
            check("div1",  n, div1,  vecs[i].d1);
            check("tick1", n, tick1, vecs[i].t1 & TICK_ON);
        end

        // Continue through edge 45: high 5 / low 5 for HALF=5, toggle for HALF=1.
        for (int e = 26; e <= 45; e++) begin
            step();
            check("div5_run",  n, div5,  ((n / 5) % 2) == 1);
            check("tick5_run", n, tick5, TICK_ON && (n % 5 == 0) && ((n / 5) % 2 == 1));
            check("div1_run",  n, div1,  (n % 2) == 1);
            check("tick1_run", n, tick1, TICK_ON && (n % 2 == 1));
        end

        // Mid-period asynchronous reset: restart, go to edge 7 (high, count 2).
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        n = 0;
        while (n < 7) step();
        check("div5_pre_rst", n, div5, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("div5_async_rst",  n, div5,  1'b0);
        check("tick5_async_rst", n, tick5, 1'b0);
        check("div1_async_rst",  n, div1,  1'b0);
        @(negedge clk50);
        rst_n = 1'b1;
        n = 0;
        while (n < 4) step();
        check("div5_after_rst_e4", n, div5,  1'b0);
        check("tick5_after_rst_e4", n, tick5, 1'b0);
        step();
        check("div5_after_rst_e5",  n, div5,  1'b1);
        check("tick5_after_rst_e5", n, tick5, TICK_ON);
        step();
        check("tick5_after_rst_e6", n, tick5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
